mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (LDUR/STUR data access) of the pipelined LEGv8 core.
- Sequences variable-latency memory transactions with a req/ready handshake.
- Gives the data side priority and raises one pipeline stall until both sides' accesses for the current cycle are satisfied.
- Handles branch-flush cancellation of an in-flight fetch.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one unified memory port between instruction fetch (IF) and data access (MEM).
// Latency: an access completes in its mem_ready cycle; best case 2 cycles for a lone fetch, 4 for load+fetch.
// Backpressure: stall is held until every access of the current pipeline cycle is satisfied; data wins over fetch.
module mem_port_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   input  logic               if_flush,
   output logic [INSTR_W-1:0] if_rdata,
   input  logic               dm_read,
   input  logic               dm_write,
   input  logic [ADDR_W-1:0]  dm_addr,
   input  logic [DATA_W-1:0]  dm_wdata,
   output logic [DATA_W-1:0]  dm_rdata,
   output logic               stall,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                if_done_q, if_done_d;
   logic                dm_done_q, dm_done_d;
   logic [INSTR_W-1:0]  if_hold_q, if_hold_d;
   logic [DATA_W-1:0]   dm_hold_q, dm_hold_d;

   logic                dm_any;
   logic                if_set;
   logic                dm_set;
   logic                if_ok;
   logic                dm_ok;
   logic [INSTR_W-1:0]  sel_half;
   logic [ADDR_W-1:0]   if_word_addr;
   logic [ADDR_W-1:0]   dm_word_addr;
   logic                unused_addr_bits;

   // Memory is word addressed: byte-offset bits never reach the port.
   assign if_word_addr     = {if_addr[ADDR_W-1:3], 3'b000};
   assign dm_word_addr     = {dm_addr[ADDR_W-1:3], 3'b000};
   assign unused_addr_bits = ^{if_addr[1:0], dm_addr[2:0]};

   assign dm_any   = dm_read | dm_write;
   // Two instructions per memory word; address bit 2 picks the upper one.
   assign sel_half = if_addr[2] ? mem_rdata[2*INSTR_W-1:INSTR_W] : mem_rdata[INSTR_W-1:0];

   // A side is satisfied once its done flag is set or its completion arrives this cycle.
   assign if_ok = if_done_q | ((state_q == FETCH) & mem_ready & ~if_flush);
   assign dm_ok = dm_done_q | ((state_q == DATA) & mem_ready);

   // Flushed fetches never stall on their own; an abandoned fetch still in the memory does.
   assign stall = (if_req & ~if_flush & ~if_ok)
                | (dm_any & ~dm_ok)
                | (state_q == DRAIN);

   assign mem_req   = (state_q != IDLE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Results come straight from the memory in the completion cycle, from the hold registers afterwards.
   assign if_rdata = if_done_q ? if_hold_q : sel_half;
   assign dm_rdata = dm_done_q ? dm_hold_q : mem_rdata;

   // Next-state and request-register logic: data has priority in IDLE, request fields load only on IDLE exit.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      if_set  = 1'b0;
      dm_set  = 1'b0;
      case (state_q)
         IDLE: begin
            if (dm_any && !dm_done_q) begin
               state_d = DATA;
               addr_d  = dm_word_addr;
               we_d    = dm_write;
               wdata_d = dm_wdata;
            end else if (if_req && !if_done_q && !if_flush) begin
               state_d = FETCH;
               addr_d  = if_word_addr;
               we_d    = 1'b0;
               wdata_d = '0;
            end
         end
         DATA: begin
            if (mem_ready) begin
               state_d = IDLE;
               dm_set  = 1'b1;
            end
         end
         FETCH: begin
            if (mem_ready) begin
               state_d = IDLE;
               if_set  = ~if_flush;
            end else if (if_flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Done flags and hold registers: flags clear whenever the pipeline advances (stall low).
   always_comb begin
      if_done_d = stall ? (if_done_q | if_set) : 1'b0;
      dm_done_d = stall ? (dm_done_q | dm_set) : 1'b0;
      if_hold_d = if_set ? sel_half  : if_hold_q;
      dm_hold_d = dm_set ? mem_rdata : dm_hold_q;
   end

   // State and request registers; reset withdraws any outstanding request at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         if_done_q <= 1'b0;
         dm_done_q <= 1'b0;
         if_hold_q <= '0;
         dm_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         if_done_q <= if_done_d;
         dm_done_q <= dm_done_d;
         if_hold_q <= if_hold_d;
         dm_hold_q <= dm_hold_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter against a transaction-level reference model.
// Latency: memory responder answers after a per-transaction latency taken from a queue.
// Backpressure: pipeline steps advance only on cycles where stall is low.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_flush;
   logic [31:0] if_rdata;
   logic        dm_read;
   logic        dm_write;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic [63:0] dm_rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ready;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } txn_t;

   txn_t        log_q[$];
   int          lat_q[$];
   int          unstable = 0;
   logic [63:0] resp_mem [logic [63:0]];
   logic [63:0] ref_mem  [logic [63:0]];

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .INSTR_W(32)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] default_word(input logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0] ^ 32'h0F0F_0000};
   endfunction

   function automatic logic [63:0] ref_rd(input logic [63:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return default_word(a);
   endfunction

   function automatic logic [31:0] pick_half(input logic [63:0] w, input logic hi);
      return hi ? w[63:32] : w[31:0];
   endfunction

   // Memory responder: one transaction per request, ready after its latency, garbage data otherwise.
   initial begin : responder
      int   cnt;
      int   lat;
      txn_t cur;
      cnt = 0; lat = 1;
      cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         mem_rdata = {$urandom, $urandom};
         if (mem_req !== 1'b1) begin
            cnt = 0;
         end else begin
            if (cnt == 0) begin
               lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
               cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
            end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
               unstable++;
            end
            cnt++;
            if (cnt >= lat) begin
               mem_ready = 1'b1;
               cnt = 0;
               if (cur.we) resp_mem[cur.addr] = cur.wdata;
               else mem_rdata = resp_mem.exists(cur.addr) ? resp_mem[cur.addr] : default_word(cur.addr);
               log_q.push_back(cur);
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish (time %0t, required < 2ms)", $time);
      $fatal(1, "watchdog");
   end

   // Counts stalled cycles from just after the current negedge until stall drops.
   task automatic wait_done(output int cyc, output bit tmo);
      cyc = 0; tmo = 1'b0;
      #1;
      while (stall === 1'b1 && !tmo) begin
         cyc++;
         if (cyc > 200) tmo = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
   endtask

   // One pipeline cycle: present requests, wait for stall to drop, capture results.
   task automatic do_step(input logic rd, input logic wr, input logic [63:0] da, input logic [63:0] dw,
                          input logic ifr, input logic [63:0] ia,
                          output int cyc, output logic [31:0] ir, output logic [63:0] dr, output bit tmo);
      @(negedge clk);
      dm_read = rd; dm_write = wr; dm_addr = da; dm_wdata = dw;
      if_req = ifr; if_addr = ia; if_flush = 1'b0;
      wait_done(cyc, tmo);
      ir = if_rdata;
      dr = dm_rdata;
   endtask

   task automatic test_reset;
      @(posedge clk); @(posedge clk);
      @(negedge clk); #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      n_checks++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      n_checks++; if (mem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
      if_req = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req got=%b exp=1", stall); end
      @(negedge clk); #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req got=%b exp=0", mem_req); end
      if_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_lone_fetch;
      int cyc; bit tmo; logic [31:0] ir; logic [63:0] dr;
      resp_mem[64'h100] = 64'hAAAA_BBBB_CCCC_DDDD;
      ref_mem[64'h100]  = 64'hAAAA_BBBB_CCCC_DDDD;
      lat_q.delete(); log_q.delete();
      lat_q.push_back(4);
      do_step(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h104, cyc, ir, dr, tmo);
      n_checks++; if (tmo) begin n_fail++; $display("FAIL lone_timeout got=timeout exp=done"); end
      n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL lone_stall_cycles got=%0d exp=4", cyc); end
      n_checks++; if (ir !== 32'hAAAABBBB) begin n_fail++; $display("FAIL lone_if_rdata got=%h exp=aaaabbbb", ir); end
      n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL lone_txn_count got=%0d exp=1", log_q.size()); end
      else begin
         n_checks++;
         if (log_q[0].addr !== 64'h100 || log_q[0].we !== 1'b0) begin
            n_fail++; $display("FAIL lone_txn got=we%b@%h exp=we0@100", log_q[0].we, log_q[0].addr);
         end
      end
   endtask

   task automatic test_load_fetch;
      int cyc; bit tmo; logic [31:0] ir; logic [63:0] dr;
      for (int rep = 0; rep < 2; rep++) begin
         lat_q.delete(); log_q.delete();
         lat_q.push_back(1); lat_q.push_back(1);
         do_step(1'b1, 1'b0, 64'h2000, 64'h0, 1'b1, 64'h0, cyc, ir, dr, tmo);
         n_checks++; if (tmo) begin n_fail++; $display("FAIL ldf_timeout rep=%0d got=timeout exp=done", rep); end
         n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL ldf_stall_cycles rep=%0d got=%0d exp=3", rep, cyc); end
         n_checks++; if (dr !== ref_rd(64'h2000)) begin n_fail++; $display("FAIL ldf_dm_rdata rep=%0d got=%h exp=%h", rep, dr, ref_rd(64'h2000)); end
         n_checks++; if (ir !== pick_half(ref_rd(64'h0), 1'b0)) begin n_fail++; $display("FAIL ldf_if_rdata rep=%0d got=%h exp=%h", rep, ir, pick_half(ref_rd(64'h0), 1'b0)); end
         n_checks++; if (log_q.size() != 2) begin n_fail++; $display("FAIL ldf_txn_count rep=%0d got=%0d exp=2", rep, log_q.size()); end
         else begin
            n_checks++;
            if (log_q[0].addr !== 64'h2000 || log_q[0].we !== 1'b0 || log_q[1].addr !== 64'h0 || log_q[1].we !== 1'b0) begin
               n_fail++; $display("FAIL ldf_order rep=%0d got=%h,%h exp=2000,0", rep, log_q[0].addr, log_q[1].addr);
            end
         end
      end
   endtask

   task automatic test_store;
      int cyc; bit tmo; logic [31:0] ir; logic [63:0] dr;
      lat_q.delete(); log_q.delete(); unstable = 0;
      lat_q.push_back(3);
      do_step(1'b0, 1'b1, 64'h18, 64'h1234, 1'b0, 64'h0, cyc, ir, dr, tmo);
      ref_mem[64'h18] = 64'h1234;
      n_checks++; if (tmo || cyc != 3) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=3", cyc); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL store_stable got=%0d exp=0 changes", unstable); end
      n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL store_txn_count got=%0d exp=1", log_q.size()); end
      else begin
         n_checks++;
         if (log_q[0].we !== 1'b1 || log_q[0].addr !== 64'h18 || log_q[0].wdata !== 64'h1234) begin
            n_fail++; $display("FAIL store_txn got=we%b@%h=%h exp=we1@18=1234", log_q[0].we, log_q[0].addr, log_q[0].wdata);
         end
      end
      lat_q.push_back(2);
      do_step(1'b1, 1'b0, 64'h1C, 64'h0, 1'b0, 64'h0, cyc, ir, dr, tmo);
      n_checks++; if (dr !== 64'h1234) begin n_fail++; $display("FAIL store_readback got=%h exp=1234", dr); end
   endtask

   task automatic test_flush_mid;
      int cyc; bit tmo;
      lat_q.delete(); log_q.delete();
      lat_q.push_back(5); lat_q.push_back(1);
      @(negedge clk);
      dm_read = 1'b0; dm_write = 1'b0; if_req = 1'b1; if_addr = 64'h40; if_flush = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_mid_req got=%b exp=1", mem_req); end
      if_flush = 1'b1; if_addr = 64'h84;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_mid_stall got=%b exp=0", stall); end
      @(negedge clk);
      if_flush = 1'b0;
      wait_done(cyc, tmo);
      n_checks++; if (tmo || cyc != 5) begin n_fail++; $display("FAIL flush_mid_stall_cycles got=%0d exp=5", cyc); end
      n_checks++; if (if_rdata !== pick_half(ref_rd(64'h80), 1'b1)) begin n_fail++; $display("FAIL flush_mid_if_rdata got=%h exp=%h", if_rdata, pick_half(ref_rd(64'h80), 1'b1)); end
      n_checks++; if (log_q.size() != 2) begin n_fail++; $display("FAIL flush_mid_txn_count got=%0d exp=2", log_q.size()); end
      else begin
         n_checks++;
         if (log_q[0].addr !== 64'h40 || log_q[1].addr !== 64'h80) begin
            n_fail++; $display("FAIL flush_mid_addrs got=%h,%h exp=40,80", log_q[0].addr, log_q[1].addr);
         end
      end
   endtask

   task automatic test_flush_ready;
      int cyc; bit tmo; logic [31:0] ir; logic [63:0] dr;
      lat_q.delete(); log_q.delete();
      lat_q.push_back(2); lat_q.push_back(1);
      @(negedge clk);
      dm_read = 1'b0; dm_write = 1'b0; if_req = 1'b1; if_addr = 64'h200; if_flush = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL flush_rdy_timing got=%b exp=1", mem_ready); end
      if_flush = 1'b1; if_addr = 64'h304;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_rdy_stall got=%b exp=0", stall); end
      do_step(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h304, cyc, ir, dr, tmo);
      n_checks++; if (tmo || cyc != 1) begin n_fail++; $display("FAIL flush_rdy_refetch_cycles got=%0d exp=1", cyc); end
      n_checks++; if (ir !== pick_half(ref_rd(64'h300), 1'b1)) begin n_fail++; $display("FAIL flush_rdy_if_rdata got=%h exp=%h", ir, pick_half(ref_rd(64'h300), 1'b1)); end
      n_checks++; if (log_q.size() != 2) begin n_fail++; $display("FAIL flush_rdy_txn_count got=%0d exp=2", log_q.size()); end
   endtask

   task automatic test_flush_idle;
      int cyc; bit tmo; logic [31:0] ir; logic [63:0] dr;
      lat_q.delete(); log_q.delete();
      @(negedge clk);
      dm_read = 1'b0; dm_write = 1'b0; if_req = 1'b1; if_addr = 64'h400; if_flush = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
      @(negedge clk); #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_req got=%b exp=0", mem_req); end
      lat_q.push_back(1);
      do_step(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h400, cyc, ir, dr, tmo);
      n_checks++; if (tmo || cyc != 1 || log_q.size() != 1) begin n_fail++; $display("FAIL flush_idle_fetch got=%0d cyc/%0d txn exp=1/1", cyc, log_q.size()); end
   endtask

   task automatic test_async_reset;
      int cyc; bit tmo; int k;
      lat_q.delete(); log_q.delete();
      lat_q.push_back(6); lat_q.push_back(2);
      @(negedge clk);
      dm_read = 1'b1; dm_write = 1'b0; dm_addr = 64'h3000; if_req = 1'b0; if_flush = 1'b0;
      k = 0;
      @(negedge clk); #1;
      while (mem_req !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL arst_issue got=%b exp=1", mem_req); end
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req_drop got=%b exp=0", mem_req); end
      n_checks++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL arst_addr got=%h exp=0", mem_addr); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL arst_stall got=%b exp=1", stall); end
      @(negedge clk);
      reset = 1'b1;
      n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL arst_no_complete got=%0d exp=0", log_q.size()); end
      wait_done(cyc, tmo);
      n_checks++; if (tmo || cyc != 2) begin n_fail++; $display("FAIL arst_reissue_cycles got=%0d exp=2", cyc); end
      n_checks++; if (dm_rdata !== ref_rd(64'h3000)) begin n_fail++; $display("FAIL arst_dm_rdata got=%h exp=%h", dm_rdata, ref_rd(64'h3000)); end
      n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL arst_txn_count got=%0d exp=1", log_q.size()); end
   endtask

   task automatic test_random;
      int cyc; bit tmo; logic [31:0] ir; logic [63:0] dr;
      logic rd, wr, ifr;
      logic [63:0] da, dw, ia, exp_dr;
      logic [31:0] exp_ir;
      int op, ld, lf, total;
      txn_t t;
      txn_t exp_q[$];
      unstable = 0;
      for (int s = 0; s < 60; s++) begin
         op  = $urandom_range(0, 3);
         rd  = (op == 1 || op == 3);
         wr  = (op >= 2);
         ifr = ($urandom_range(0, 3) != 0);
         da  = 64'($urandom_range(0, 31)) << 2;
         ia  = 64'($urandom_range(0, 31)) << 2;
         dw  = {$urandom, $urandom};
         lat_q.delete(); log_q.delete(); exp_q.delete();
         total = 0; exp_dr = '0; exp_ir = '0;
         if (rd || wr) begin
            ld = $urandom_range(1, 4);
            lat_q.push_back(ld);
            total += 1 + ld;
            t.we = wr; t.addr = da & ~64'h7; t.wdata = dw;
            exp_q.push_back(t);
            if (wr) ref_mem[t.addr] = dw;
            else exp_dr = ref_rd(t.addr);
         end
         if (ifr) begin
            lf = $urandom_range(1, 4);
            lat_q.push_back(lf);
            total += 1 + lf;
            t.we = 1'b0; t.addr = ia & ~64'h7; t.wdata = '0;
            exp_q.push_back(t);
            exp_ir = pick_half(ref_rd(t.addr), ia[2]);
         end
         do_step(rd, wr, da, dw, ifr, ia, cyc, ir, dr, tmo);
         n_checks++;
         if (tmo || cyc != ((total == 0) ? 0 : total - 1)) begin
            n_fail++; $display("FAIL rand_stall s=%0d got=%0d exp=%0d", s, cyc, (total == 0) ? 0 : total - 1);
         end
         n_checks++;
         if (log_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_txn_count s=%0d got=%0d exp=%0d", s, log_q.size(), exp_q.size());
         end else begin
            foreach (exp_q[i]) begin
               n_checks++;
               if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
                   (exp_q[i].we && log_q[i].wdata !== exp_q[i].wdata)) begin
                  n_fail++; $display("FAIL rand_txn s=%0d i=%0d got=we%b@%h=%h exp=we%b@%h=%h", s, i,
                     log_q[i].we, log_q[i].addr, log_q[i].wdata, exp_q[i].we, exp_q[i].addr, exp_q[i].wdata);
               end
            end
         end
         if (rd && !wr) begin
            n_checks++; if (dr !== exp_dr) begin n_fail++; $display("FAIL rand_dm_rdata s=%0d got=%h exp=%h", s, dr, exp_dr); end
         end
         if (ifr) begin
            n_checks++; if (ir !== exp_ir) begin n_fail++; $display("FAIL rand_if_rdata s=%0d got=%h exp=%h", s, ir, exp_ir); end
         end
      end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL rand_req_stable got=%0d exp=0 changes", unstable); end
   endtask

   initial begin : main
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
      test_reset();
      test_lone_fetch();
      test_load_fetch();
      test_store();
      test_flush_mid();
      test_flush_ready();
      test_flush_idle();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
